mux: RTL and testbench

- Registered 2:1 address multiplexer in the FIR/AXI sample-memory path.
- Selects the sample-memory address source:
  - the AXI-side address (a_address) while the AXI interface owns the memory;
  - the FIR engine's sample address (A_probka_FIR) while the FIR FSM is computing.
- The select signal comes from the control FSM (FSM_MUX).
- The output drives the sample RAM address port through one pipeline register.

---
 rtl/mux.sv | 35 +++
 tb/tb_mux.sv | 109 ++++++++++
 2 files changed

// File: rtl/mux.sv
// Registered 2:1 sample-memory address multiplexer: picks the AXI or FIR address
// according to FSM_MUX and presents it to the sample RAM one clock later.
module mux #(
   parameter int WIDTH = 13
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A_probka_FIR,
   input  logic [WIDTH-1:0] a_address,
   input  logic             FSM_MUX,
   output logic [WIDTH-1:0] probka_address
);

   logic [WIDTH-1:0] probka_address_d;
   logic [WIDTH-1:0] probka_address_q;

   // FSM_MUX = 1 hands the memory to the FIR engine, 0 to the AXI side.
   always_comb begin
      probka_address_d = a_address;
      if (FSM_MUX) begin
         probka_address_d = A_probka_FIR;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         probka_address_q <= '0;
      end else begin
         probka_address_q <= probka_address_d;
      end
   end

   assign probka_address = probka_address_q;

endmodule

// File: tb/tb_mux.sv
// Self-checking bench for mux: directed steps from the test plan followed by
// randomized traffic, compared against a behavioural model of the selection rules.
module tb_mux;

   localparam int WIDTH = 13;
   localparam int MAXV  = (1 << WIDTH) - 1;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] A_probka_FIR;
   logic [WIDTH-1:0] a_address;
   logic             FSM_MUX;
   logic [WIDTH-1:0] probka_address;

   int checks;
   int failures;
   logic [WIDTH-1:0] exp_q;
   bit               exp_valid;

   mux #(.WIDTH(WIDTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .A_probka_FIR   (A_probka_FIR),
      .a_address      (a_address),
      .FSM_MUX        (FSM_MUX),
      .probka_address (probka_address)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // One clock: drive inputs mid-cycle, confirm the output has not moved yet,
   // then confirm the registered result just after the rising edge.
   task automatic step(input logic r, input logic s, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] f, input string tag);
      logic [WIDTH-1:0] next_exp;
      @(negedge clk);
      rst          = r;
      FSM_MUX      = s;
      a_address    = a;
      A_probka_FIR = f;
      #1;
      if (exp_valid) chk({tag, "_hold"}, probka_address, exp_q);
      if (r)      next_exp = '0;
      else if (s) next_exp = f;
      else        next_exp = a;
      @(posedge clk);
      #1;
      exp_q     = next_exp;
      exp_valid = 1'b1;
      chk(tag, probka_address, exp_q);
      $display("step %-10s rst=%0d sel=%0d axi=%0d fir=%0d -> out=%0d exp=%0d",
               tag, r, s, a, f, probka_address, exp_q);
   endtask

   initial begin
      logic r, s;
      logic [WIDTH-1:0] a, f;
      checks    = 0;
      failures  = 0;
      exp_valid = 1'b0;
      exp_q     = '0;
      rst = 1'b1; FSM_MUX = 1'b1; a_address = 10; A_probka_FIR = 100;

      // Reset held two cycles with FIR selected, then released
      step(1'b1, 1'b1, 13'd10, 13'd100, "reset0");
      step(1'b1, 1'b1, 13'd10, 13'd100, "reset1");
      step(1'b0, 1'b1, 13'd10, 13'd100, "rst_rel");
      // AXI select, FIR select, tracking, return to AXI
      step(1'b0, 1'b0, 13'd10,  13'd100, "axi_sel");
      step(1'b0, 1'b0, 13'd10,  13'd777, "axi_ign");
      step(1'b0, 1'b1, 13'd10,  13'd100, "fir_sel");
      step(1'b0, 1'b1, 13'd10,  13'd200, "fir_trk");
      step(1'b0, 1'b1, 13'd999, 13'd200, "fir_ign");
      step(1'b0, 1'b0, 13'd55,  13'd200, "axi_ret");
      // Boundaries
      step(1'b0, 1'b0, 13'd8191, 13'd0,  "axi_max");
      step(1'b0, 1'b1, 13'd8191, 13'd0,  "fir_zero");
      step(1'b0, 1'b1, 13'd0, 13'd8191,  "fir_max");
      // Reset mid-operation, then resume
      step(1'b1, 1'b0, 13'd321, 13'd654, "rst_mid");
      step(1'b0, 1'b0, 13'd321, 13'd654, "resume");
      // Select toggling every cycle
      for (int i = 0; i < 6; i++) begin
         step(1'b0, logic'(i % 2), 13'd1234, 13'd4321, "toggle");
      end

      // Randomized traffic with occasional reset
      for (int i = 0; i < 200; i++) begin
         r = ($urandom_range(0, 15) == 0);
         s = logic'($urandom_range(0, 1));
         a = WIDTH'($urandom_range(0, MAXV));
         f = WIDTH'($urandom_range(0, MAXV));
         step(r, s, a, f, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
